// File: rtl/jk_onoff_fsm_pkg.sv
// jk_onoff_pkg: state encoding and counter width shared by the JK on/off FSM files.
package jk_onoff_pkg;
    typedef enum logic [0:0] {OFF = 1'b0, ON = 1'b1} state_e;
    localparam int CNT_W = 8;
endpackage

// File: rtl/jk_onoff_fsm_if.sv
// jk_onoff_fsm_if: request/response bundle of the JK on/off FSM.
// With JK_ONOFF_FSM_TOGGLE_CNT_EN defined it also carries toggle_cnt.
interface jk_onoff_fsm_if;
    import jk_onoff_pkg::*;
    logic j;
    logic k;
    logic dout;
`ifdef JK_ONOFF_FSM_TOGGLE_CNT_EN
    logic [CNT_W-1:0] toggle_cnt;
    modport master (output j, k, input dout, toggle_cnt);
    modport slave  (input j, k, output dout, toggle_cnt);
`else
    modport master (output j, k, input dout);
    modport slave  (input j, k, output dout);
`endif
endinterface

// File: rtl/jk_onoff_fsm.sv
// jk_onoff_fsm: two-state Moore FSM, j turns on and k turns off; async active-low reset.
// JK_ONOFF_FSM_TOGGLE_CNT_EN adds an 8-bit wrapping count of state changes.
module jk_onoff_fsm
    import jk_onoff_pkg::*;
#(
    parameter bit RESET_ON = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    jk_onoff_fsm_if.slave bus
);
    localparam logic [0:0] S_OFF = OFF;
    localparam logic [0:0] S_ON  = ON;
    localparam logic [0:0] S_RST = RESET_ON ? S_ON : S_OFF;

    logic [0:0] state_q, state_d;

    always_comb begin
        state_d  = state_q == S_OFF ? (bus.j ? S_ON : S_OFF) : (bus.k ? S_OFF : S_ON);
        bus.dout = state_q == S_ON;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_RST;
        else        state_q <= state_d;
    end

`ifdef JK_ONOFF_FSM_TOGGLE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d          = cnt_q + CNT_W'(state_d != state_q);
        bus.toggle_cnt = cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_jk_onoff_fsm.sv
// tb_jk_onoff_fsm: scoreboard bench for jk_onoff_fsm (default RESET_ON=0).
// Expected dout/toggle_cnt are queued as stimulus is applied and popped when sampled.
module tb_jk_onoff_fsm;
    import jk_onoff_pkg::*;

    typedef struct {
        logic             dout;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];
    logic m_st = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;

    jk_onoff_fsm_if bus ();

    jk_onoff_fsm #(.RESET_ON(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk(tag, 32'(bus.dout), 32'(e.dout));
`ifdef JK_ONOFF_FSM_TOGGLE_CNT_EN
        chk({tag, "_cnt"}, 32'(bus.toggle_cnt), 32'(e.cnt));
`endif
    endtask

    task automatic model_reset();
        m_st  = 1'b0;
        m_cnt = '0;
    endtask

    task automatic model_edge(input logic jj, input logic kk);
        logic nxt;
        if (!reset) return;
        nxt = m_st ? ~kk : jj;
        if (nxt != m_st) m_cnt++;
        m_st = nxt;
    endtask

    // Drive one edge of j/k; the required dout comes from the caller, the count from the model.
    task automatic tick(input logic jj, input logic kk, input logic ed, input string tag);
        bus.j = jj;
        bus.k = kk;
        @(posedge clk);
        model_edge(jj, kk);
        sb.push_back('{ed, m_cnt});
        #1 check_out(tag);
    endtask

    logic [1:0] seq_kj [12] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10,
                                2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic       seq_d  [12] = '{0, 1, 1, 1, 1, 0, 0, 1, 0, 1, 0, 1};
    logic       tog_d  [4]  = '{1, 0, 1, 0};

    initial begin
        bus.j = 1'b1;
        bus.k = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 sb.push_back('{1'b0, 8'd0});
        check_out("reset_state");
        @(negedge clk);
        reset = 1'b1;
        #1 sb.push_back('{1'b0, 8'd0});
        check_out("release_no_edge");

        tick(1, 0, 1, "turn_on");
        tick(0, 1, 0, "turn_off");
        for (int i = 0; i < 3; i++) tick(0, 1, 0, "hold_off");
        tick(1, 0, 1, "turn_on2");
        for (int i = 0; i < 3; i++) tick(1, 0, 1, "hold_on");
        tick(0, 1, 0, "turn_off2");
        for (int i = 0; i < 4; i++) tick(1, 1, tog_d[i], "toggle");
        for (int i = 0; i < 12; i++) tick(seq_kj[i][0], seq_kj[i][1], seq_d[i], "dir_seq");

        // state is ON here; pull reset mid-cycle and expect OFF before the next edge
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1 sb.push_back('{1'b0, 8'd0});
        check_out("async_reset");
        for (int i = 0; i < 3; i++) tick(1, 0, 0, "reset_hold");
        @(negedge clk);
        reset = 1'b1;
        tick(1, 0, 1, "post_reset_on");

        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #2;
            bus.j = 1'($urandom_range(0, 1));
            bus.k = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 7) != 0);
            if (!reset) model_reset();
            #1 sb.push_back('{m_st, m_cnt});
            check_out("rand_lo");
            @(posedge clk);
            model_edge(bus.j, bus.k);
            sb.push_back('{m_st, m_cnt});
            #1 check_out("rand_edge");
            #2 reset = ($urandom_range(0, 7) != 0);
            if (!reset) model_reset();
            #1 sb.push_back('{m_st, m_cnt});
            check_out("rand_hi");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/jk_onoff_fsm.md
Name: jk_onoff_fsm

Overview:
- Two-state Moore FSM with states OFF and ON.
- Input j turns the machine on; input k turns it off. Output dout is 1 exactly while in ON.
- Used as a small JK-style latch/controller leaf cell; fully registered state, output decoded from state only.

Parameters:
- RESET_ON, 0, reset state select: 0 means reset to OFF (dout=0); 1 means reset to ON (dout=1). Default build uses 0.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- j  input  1  turn-on request, sampled in OFF
- k  input  1  turn-off request, sampled in ON
- dout  output  1  1 when state is ON, 0 when OFF (Moore output)

Behaviour:
- One clock; reset is asynchronous and active-low.
- reset=0 forces state to OFF immediately, without waiting for a clock edge (or to ON if RESET_ON=1). dout follows within the same delta.
- While reset=0 the state is held; j and k are ignored.
- Release (reset 0->1) takes effect at the first rising clk edge after release. The first transition is evaluated on that edge.
- Transitions on the rising clk edge with reset=1:
  - OFF: j=1 -> ON; j=0 -> OFF (k ignored).
  - ON: k=1 -> OFF; k=0 -> ON (j ignored).
- j=k=1: OFF goes to ON and ON goes to OFF, so the state toggles every cycle.
- dout = (state==ON). It is purely state-decoded, with no combinational path from j or k. Latency from request to output is 1 cycle.
- j and k are single-bit, non-X inputs. The state register must never hold X after reset.
- Reset asserted mid-operation (any phase of clk) returns the FSM to the reset state at once.
- State encoding: 1 bit, OFF=0, ON=1.

Optional Feature:
- Macro: JK_ONOFF_FSM_TOGGLE_CNT_EN.
- Defined: adds output port toggle_cnt [7:0].
  - Increments on every clock edge where the state changes (OFF<->ON) and wraps 255->0.
  - Cleared to 0 by asynchronous reset.
  - dout behaviour is unchanged.
- Undefined: port and counter are absent; the block is only the 2-state FSM.

Decomposition:
- Package jk_onoff_pkg:
  - state typedef (enum logic [0:0] {OFF=1'b0, ON=1'b1})
  - constant for the counter width (8)
- No sub-module. One module holds a state register plus next-state logic. The optional counter sits in the same module, guarded by the macro.

Test Plan:
- Async reset: assert reset=0 mid-cycle with state ON -> dout=0 before the next rising edge. State stays OFF for all clocks while reset=0, even with j=1.
- Turn on/off: from OFF, j=1,k=0 for one edge -> dout=1 after that edge. Then j=0,k=1 for one edge -> dout=0.
- Hold behaviour: in OFF, hold j=0 with k=1 for 3 edges -> dout stays 0. In ON, hold k=0 with j=1 for 3 edges -> dout stays 1.
- Toggle: j=k=1 for 4 consecutive edges starting from OFF -> dout sequence 1,0,1,0.
- Directed sequence from OFF, {k,j} per edge = 00,01,01,01,00,10,10,11,11,11,11,11 -> dout = 0,1,1,1,1,0,0,1,0,1,0,1.
- Random: 200 cycles of random j,k, with reset asserted (0) roughly 1 in 8 half-cycles -> dout matches a golden 2-state model on both clock edges. With JK_ONOFF_FSM_TOGGLE_CNT_EN defined, toggle_cnt equals the number of state changes since the last reset, mod 256.
